// File: rtl/exp_block_collector.sv
// exp_block_collector: gathers serial exponents into one registered block.
// Optional running max output under EXP_COLLECTOR_RUNNING_MAX_EN.
module exp_block_collector #(
  parameter int width  = 8,
  parameter int length = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [width-1:0] i_exp,
  input  logic             i_last,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [width-1:0] o_exps [length]
`ifdef EXP_COLLECTOR_RUNNING_MAX_EN
  ,
  output logic [width-1:0] o_e_max
`endif
);

  localparam int CW = $clog2(length);

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [CW-1:0] cnt_q;
  logic          acc;
  logic          done;

  // ready never looks at i_valid, so no valid->ready path
  assign o_ready = (state_q == FILL) | i_ready;
  assign o_valid = (state_q == HOLD);
  assign acc     = i_valid & o_ready;
  // cnt is 0 in HOLD, so only i_last can close a block there
  assign done    = i_last | (cnt_q == CW'(length - 1));

  // state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= FILL;
    else          state_q <= state_d;
  end

  // next state: handoff and refill may share one edge
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FILL: begin
        if (acc && done) state_d = HOLD;
      end
      HOLD: begin
        if (acc)          state_d = done ? HOLD : FILL;
        else if (i_ready) state_d = FILL;
      end
      default: state_d = FILL;
    endcase
  end

  // write pointer; wraps to slot 0 when a block closes
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)  cnt_q <= '0;
    else if (acc)  cnt_q <= done ? '0 : cnt_q + 1'b1;
  end

  // block storage; short blocks get zero padding above the last slot
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < length; i++) o_exps[i] <= '0;
    end else if (acc) begin
      for (int i = 0; i < length; i++) begin
        if (i_last && (i > int'(cnt_q))) o_exps[i] <= '0;
      end
      o_exps[cnt_q] <= i_exp;
    end
  end

`ifdef EXP_COLLECTOR_RUNNING_MAX_EN
  // running max restarts on slot 0; padding never touches it
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_e_max <= '0;
    end else if (acc) begin
      if ((cnt_q == '0) || (i_exp > o_e_max)) o_e_max <= i_exp;
    end
  end
`endif

endmodule

// File: doc/exp_block_collector.md
EXP_BLOCK_COLLECTOR -- requirements
Module: exp_block_collector

Interface
REQ-001 SHALL have parameter `width`, default 8: bit width of each unsigned exponent.
REQ-002 SHALL have parameter `length`, default 32: exponents per block; power of two, at least 2.
REQ-003 SHALL have port `i_clk`, input, 1 bit: single clock; all state changes on its rising edge.
REQ-004 SHALL have port `i_rst_n`, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port `i_valid`, input, 1 bit: upstream exponent valid.
REQ-006 SHALL have port `o_ready`, output, 1 bit: collector accepts `i_exp` this cycle.
REQ-007 SHALL have port `i_exp`, input, `width` bits: serial unsigned exponent.
REQ-008 SHALL have port `i_last`, input, 1 bit: qualified by `i_valid`; marks the final element of a (possibly partial) block.
REQ-009 SHALL have port `o_valid`, output, 1 bit: assembled block is available.
REQ-010 SHALL have port `i_ready`, input, 1 bit: downstream (max tree) consumes the block.
REQ-011 SHALL have port `o_exps`, output, unpacked array [`length`] of `width` bits: assembled block; element 0 is first-arrived.
REQ-012 SHALL have port `o_e_max`, output, `width` bits: running maximum of the block (present only under the configuration macro).

Function
REQ-013 SHALL accept an element when `i_valid` and `o_ready` are both high on a rising edge; no other event accepts one.
REQ-014 SHALL implement two states. FILL: collecting elements, `o_valid`=0. HOLD: block complete, `o_valid`=1.
REQ-015 SHALL drive `o_ready`=1 in FILL, and `o_ready`=`i_ready` in HOLD.
REQ-016 SHALL write an accepted element to `o_exps[cnt]` and increment `cnt`; `cnt` is $clog2(`length`) bits.
REQ-017 SHALL go FILL->HOLD on accepting an element when `cnt`==`length`-1 or `i_last`=1, then reset `cnt` to 0.
REQ-018 SHALL, on a FILL->HOLD transition caused by `i_last` with `cnt`<`length`-1, zero every slot above the last written one in that same edge.
REQ-019 SHALL go HOLD->FILL when `i_ready`=1 and no element is accepted that edge.
REQ-020 SHALL, when `i_ready`=1 and an element is accepted in HOLD, complete the handoff and write the element to slot 0 of the new block with `cnt`=1, in the same edge.
REQ-021 SHALL handle a same-edge hand-off where the new element also carries `i_last`: slot 0 written, slots 1..`length`-1 zeroed, state remains HOLD.
REQ-022 SHALL hold `o_exps` and `o_valid` stable in HOLD while `i_ready`=0.
REQ-023 SHALL register `o_exps`; the block becomes visible one cycle after its final element is accepted. Back-to-back full blocks sustain one element per cycle.
REQ-024 SHALL have `o_ready` depend only on state and `i_ready`, with no path from `i_valid`.

Reset
REQ-025 SHALL, on `i_rst_n` low, asynchronously set: state=FILL, `cnt`=0, `o_valid`=0, `o_ready`=1, all `o_exps`=0, `o_e_max`=0.
REQ-026 SHALL, on reset mid-block, discard any partial block; the first element accepted after release lands in slot 0.

Configuration
REQ-027 SHALL use the macro EXP_COLLECTOR_RUNNING_MAX_EN to control the running-maximum feature.
REQ-028 SHALL, when EXP_COLLECTOR_RUNNING_MAX_EN is defined, provide `o_e_max` as a register updated on each accept:
- slot 0: `o_e_max` <= `i_exp`
- other slots: `o_e_max` <= max(`o_e_max`, `i_exp`)
- it is valid with `o_valid`; zero padding does not alter it.
REQ-029 SHALL, when EXP_COLLECTOR_RUNNING_MAX_EN is undefined, omit the `o_e_max` port and its logic entirely; all other behaviour is identical.

Verification
REQ-030 SHALL cover full block: `length`=4, `i_ready`=1, stream 3,9,1,7 on consecutive cycles -> next cycle `o_valid`=1, `o_exps`={3,9,1,7}, `o_e_max`=9 (macro on).
REQ-031 SHALL cover partial block: stream 5,2 with `i_last` on 2 -> `o_exps`={5,2,0,0}, `o_e_max`=5.
REQ-032 SHALL cover backpressure: hold `i_ready`=0 for 3 cycles in HOLD -> `o_ready`=0, `o_exps` unchanged; raise `i_ready` with `i_valid`=1, `i_exp`=4 -> new block slot 0 = 4.
REQ-033 SHALL cover back-to-back: 8 consecutive elements 0..7 with `i_ready`=1 -> two blocks {0,1,2,3} and {4,5,6,7}, no bubble, `o_ready` constantly 1.
REQ-034 SHALL cover reset mid-block: accept 2 elements, pulse `i_rst_n` low -> `o_valid`=0 immediately; then stream 8,8,8,8 -> `o_exps`={8,8,8,8}.
